// File: rtl/move_request_gen.sv
// Push-button front end for the 2048 core: synchronizes and debounces KEY[3:0]
// and issues one held one-hot move request per physical press.
module move_request_gen #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       keys_n,
    input  logic             move_ack,
    output logic [3:0]       move_dir,
    output logic             move_valid,
    output logic             multi_err,
    output logic [CNT_W-1:0] move_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_deb;
    logic [DB_W-1:0]  r_stable_cnt;
    state_t           r_state;
    logic [3:0]       r_dir;
    logic             r_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_next;
    logic [3:0]       w_dir_d;
    logic             w_valid_d;
    logic             w_err_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_any;
    logic             w_onehot;

    // r_sync1 is the sample about to enter r_sync2, so a mismatch between
    // the two is exactly a change of the synchronized vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1      <= 4'b0000;
            r_sync2      <= 4'b0000;
            r_deb        <= 4'b0000;
            r_stable_cnt <= '0;
        end else begin
            r_sync1 <= ~keys_n;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt != DB_MAX) begin
                r_stable_cnt <= r_stable_cnt + DB_W'(1);
            end
            if (r_stable_cnt == DB_MAX && r_sync2 != r_deb) begin
                r_deb <= r_sync2;
            end
        end
    end

    assign w_any    = (r_deb != 4'b0000);
    assign w_onehot = w_any && ((r_deb & (r_deb - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dir   <= 4'b0000;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_dir   <= w_dir_d;
            r_valid <= w_valid_d;
            r_err   <= w_err_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_dir_d   = r_dir;
        w_valid_d = r_valid;
        w_err_d   = 1'b0;
        w_cnt_d   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_dir_d   = r_deb;
                    w_valid_d = 1'b1;
                    w_next    = S_REQ;
                end else if (w_any) begin
                    w_err_d = 1'b1;
                    w_next  = S_WAIT_REL;
                end
            end
            S_REQ: begin
                if (move_ack) begin
                    w_dir_d   = 4'b0000;
                    w_valid_d = 1'b0;
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                    w_next = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (!w_any) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_dir_d   = 4'b0000;
                w_valid_d = 1'b0;
                w_next    = S_IDLE;
            end
        endcase
    end

    assign move_dir   = r_dir;
    assign move_valid = r_valid;
    assign multi_err  = r_err;
    assign move_count = r_cnt;

endmodule

// File: tb/tb_move_request_gen.sv
// Directed bench for move_request_gen with DEBOUNCE_CYCLES=4; a second
// instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_move_request_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  keys_n = 4'b1111;
    logic        move_ack = 1'b0;

    logic [3:0]  move_dir;
    logic        move_valid;
    logic        multi_err;
    logic [15:0] move_count;

    logic [3:0]  s_dir;
    logic        s_valid;
    logic        s_err;
    logic [1:0]  s_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic seen;

    always #5 clk = ~clk;

    move_request_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .keys_n(keys_n), .move_ack(move_ack),
        .move_dir(move_dir), .move_valid(move_valid),
        .multi_err(multi_err), .move_count(move_count)
    );

    move_request_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .keys_n(keys_n), .move_ack(move_ack),
        .move_dir(s_dir), .move_valid(s_valid),
        .multi_err(s_err), .move_count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a press and check the request appears on exactly the 7th edge.
    task automatic press(input string tag, input logic [3:0] k,
                         input logic [3:0] dir);
        keys_n = k;
        tick(6);
        chk({tag, "_valid_at6"}, {31'd0, move_valid}, 32'd0);
        tick(1);
        chk({tag, "_valid_at7"}, {31'd0, move_valid}, 32'd1);
        chk({tag, "_dir"}, {28'd0, move_dir}, {28'd0, dir});
    endtask

    task automatic ack(input string tag);
        move_ack = 1'b1;
        tick(1);
        move_ack = 1'b0;
        exp_cnt++;
        chk({tag, "_ack_valid"}, {31'd0, move_valid}, 32'd0);
        chk({tag, "_ack_dir"}, {28'd0, move_dir}, 32'd0);
        chk({tag, "_ack_cnt"}, {16'd0, move_count}, exp_cnt);
    endtask

    task automatic release_keys();
        keys_n = 4'b1111;
        tick(10);
    endtask

    initial begin
        // 1. asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, move_valid}, 32'd0);
        chk("rst_async_dir", {28'd0, move_dir}, 32'd0);
        chk("rst_async_err", {31'd0, multi_err}, 32'd0);
        chk("rst_async_cnt", {16'd0, move_count}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("rst_rel_valid", {31'd0, move_valid}, 32'd0);
        chk("rst_rel_dir", {28'd0, move_dir}, 32'd0);
        chk("rst_rel_cnt", {16'd0, move_count}, 32'd0);

        // 2. clean up press, held without ack, other buttons ignored
        press("up", 4'b0111, 4'b1000);
        tick(10);
        chk("up_hold_valid", {31'd0, move_valid}, 32'd1);
        chk("up_hold_dir", {28'd0, move_dir}, 32'h8);
        keys_n = 4'b0110;
        tick(10);
        chk("up_noise_dir", {28'd0, move_dir}, 32'h8);
        chk("up_noise_err", {31'd0, multi_err}, 32'd0);
        ack("up");
        release_keys();

        // 3. right bouncing every 2 cycles, then settling pressed
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            keys_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            repeat (2) begin
                tick(1);
                seen = seen | move_valid;
            end
        end
        chk("bounce_no_req", {31'd0, seen}, 32'd0);
        press("bounce", 4'b1110, 4'b0001);
        ack("bounce");
        release_keys();

        // 4. left held after ack, then re-pressed
        press("left1", 4'b1101, 4'b0010);
        ack("left1");
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            seen = seen | move_valid;
        end
        chk("left_hold_no_req", {31'd0, seen}, 32'd0);
        release_keys();
        press("left2", 4'b1101, 4'b0010);
        chk("left2_cnt_pending", {16'd0, move_count}, exp_cnt);
        ack("left2");
        release_keys();

        // 5. two buttons together are rejected with a single pulse
        keys_n = 4'b1100;
        tick(6);
        chk("multi_err_at6", {31'd0, multi_err}, 32'd0);
        tick(1);
        chk("multi_err_at7", {31'd0, multi_err}, 32'd1);
        chk("multi_valid", {31'd0, move_valid}, 32'd0);
        tick(1);
        chk("multi_err_at8", {31'd0, multi_err}, 32'd0);
        tick(5);
        chk("multi_valid_late", {31'd0, move_valid}, 32'd0);
        release_keys();
        press("down", 4'b1011, 4'b0100);
        ack("down");
        release_keys();

        // 6. ack while idle is ignored; narrow counter saturates
        move_ack = 1'b1;
        tick(5);
        move_ack = 1'b0;
        chk("spur_ack_cnt", {16'd0, move_count}, 32'd5);
        chk("spur_ack_valid", {31'd0, move_valid}, 32'd0);
        chk("sat_cnt", {30'd0, s_count}, 32'd3);

        // reset in the middle of a pending request
        press("rst_req", 4'b0111, 4'b1000);
        #3 rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'd0, move_valid}, 32'd0);
        chk("rst_req_dir", {28'd0, move_dir}, 32'd0);
        chk("rst_req_cnt", {16'd0, move_count}, 32'd0);
        chk("rst_req_sat_cnt", {30'd0, s_count}, 32'd0);
        tick(2);
        rst = 1'b0;
        keys_n = 4'b1111;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
